// File: rtl/psum_drain_ctrl.sv
// psum_drain_ctrl: sweeps the psum scratchpad 0..len-1 and streams words out over valid/ready.
// Define PSUM_DRAIN_RELU_EN to clamp negative output words to zero.
module psum_drain_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  input  logic              clear,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, FLUSH = 2'd2, DONE = 2'd3;
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] len_q, issue_q;
  logic              inflight_q, inflight_last_q;
  logic [DATA_W-1:0] buf_q [2];
  logic [1:0]        last_q;
  logic              wptr_q, rptr_q;
  logic [1:0]        occ_q;
  logic              pop, last_issue;
  logic [2:0]        fill;
  logic [DATA_W-1:0] head;
  assign out_valid = occ_q != 2'd0;
  assign out_last  = out_valid & last_q[rptr_q];
  assign head      = buf_q[rptr_q];
  assign busy      = (state_q == ISSUE) || (state_q == FLUSH);
  assign done      = state_q == DONE;
  assign rd_addr   = issue_q;
`ifdef PSUM_DRAIN_RELU_EN
  assign out_data  = head[DATA_W-1] ? '0 : head;
`else
  assign out_data  = head;
`endif
  // Issue only when buffered words plus the outstanding read, net of this cycle's pop, leave room.
  always_comb begin
    pop        = out_valid & out_ready;
    fill       = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop};
    last_issue = issue_q == len_q - 1'b1;
    rd_en      = (state_q == ISSUE) && !clear && (fill < 3'd2);
    state_d    = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (len == '0) ? DONE : ISSUE;
      ISSUE:   if (rd_en && last_issue) state_d = FLUSH;
      FLUSH:   if (pop && out_last) state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= IDLE;
      len_q           <= '0;
      issue_q         <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      buf_q[0]        <= '0;
      buf_q[1]        <= '0;
      last_q          <= '0;
      wptr_q          <= 1'b0;
      rptr_q          <= 1'b0;
      occ_q           <= '0;
    end else begin
      state_q         <= state_d;
      inflight_q      <= rd_en;
      inflight_last_q <= rd_en & last_issue;
      if (state_q == IDLE && start) begin
        len_q   <= len;
        issue_q <= '0;
      end
      if (rd_en && !last_issue) issue_q <= issue_q + 1'b1;
      // A read returning in the clear cycle's aftermath is dropped with the buffer.
      if (clear) begin
        occ_q  <= '0;
        wptr_q <= 1'b0;
        rptr_q <= 1'b0;
      end else begin
        if (inflight_q) begin
          buf_q[wptr_q]  <= rd_data;
          last_q[wptr_q] <= inflight_last_q;
          wptr_q         <= ~wptr_q;
        end
        if (pop) rptr_q <= ~rptr_q;
        occ_q <= occ_q + {1'b0, inflight_q} - {1'b0, pop};
      end
    end
  end
endmodule

// File: tb/tb_psum_drain_ctrl.sv
// tb_psum_drain_ctrl: directed bench for psum_drain_ctrl with a 1-cycle scratchpad model.
module tb_psum_drain_ctrl;
  localparam int DW = 16, AW = 5;
  logic clk = 1'b0, rstn = 1'b0, start = 1'b0, clear = 1'b0, out_ready = 1'b1;
  logic [AW-1:0] len = '0;
  logic busy, done, rd_en, out_valid, out_last;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0, out_data;
  logic [DW-1:0] mem [32];
  int tests = 0, fails = 0;
  int rd_total = 0, hs_total = 0, val_total = 0, stall_err = 0, oc = 0, max_oc = 0;
  logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [DW-1:0] pd = '0;
  logic [DW-1:0] wq[$];
  logic lq[$];

  always #5 clk = ~clk;

  psum_drain_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .len(len), .clear(clear),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // Passive monitor: collects handshaken words, read counts, stall stability and buffer fill.
  always @(negedge clk) begin
    if (!rstn) begin
      pv = 1'b0;
      oc = 0;
    end else begin
      if (pv && !pr && (!out_valid || out_data !== pd || out_last !== pl)) stall_err++;
      rd_total += int'(rd_en);
      val_total += int'(out_valid);
      if (out_valid && out_ready) begin
        hs_total++;
        wq.push_back(out_data);
        lq.push_back(out_last);
      end
      oc = clear ? 0 : oc + int'(rd_en) - int'(out_valid && out_ready);
      if (oc > max_oc) max_oc = oc;
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++;
    if ({busy, done, rd_en, out_valid, out_last} !== 5'b0) begin
      fails++; $display("FAIL reset_flags: got %b required 00000", {busy, done, rd_en, out_valid, out_last});
    end
    tests++;
    if (rd_addr !== '0 || out_data !== '0) begin
      fails++; $display("FAIL reset_bus: rd_addr=%0d out_data=%0d required 0 0", rd_addr, out_data);
    end
    @(posedge clk); #2 rstn = 1'b1;
  endtask

  task automatic test_basic();
    int r0;
    for (int i = 0; i < 4; i++) mem[i] = 16'(100 + i);
    @(posedge clk); #2 start = 1'b1; len = 5'd4; out_ready = 1'b1; r0 = rd_total;
    @(posedge clk); #2 start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      tests++;
      if ({busy, out_valid, out_last, done} !== {c <= 6, c >= 3 && c <= 6, c == 6, c == 7}) begin
        fails++; $display("FAIL basic_flags c=%0d: busy/valid/last/done=%b required %b", c,
          {busy, out_valid, out_last, done}, {c <= 6, c >= 3 && c <= 6, c == 6, c == 7});
      end
      if (c >= 3 && c <= 6) begin
        tests++;
        if (out_data !== 16'(97 + c)) begin
          fails++; $display("FAIL basic_data c=%0d: got %0d required %0d", c, out_data, 97 + c);
        end
      end
    end
    @(posedge clk); #2;
    tests++;
    if (rd_total - r0 !== 4) begin
      fails++; $display("FAIL basic_reads: got %0d required 4", rd_total - r0);
    end
  endtask

  task automatic test_backpressure();
    int w0, r0;
    bit ok;
    for (int i = 0; i < 6; i++) mem[i] = 16'(200 + 3 * i);
    @(posedge clk); #2 start = 1'b1; len = 5'd6; out_ready = 1'b1; w0 = wq.size(); r0 = rd_total;
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(posedge clk); #2 start = 1'b0; out_ready = (k % 4 == 0) || (k % 4 == 3);
      @(negedge clk); ok = done;
    end
    out_ready = 1'b1;
    tests++;
    if (!ok) begin fails++; $display("FAIL bp_done_timeout: done=0 required 1"); end
    @(posedge clk); #2;
    tests++;
    if (wq.size() - w0 !== 6 || rd_total - r0 !== 6) begin
      fails++; $display("FAIL bp_count: words=%0d reads=%0d required 6 6", wq.size() - w0, rd_total - r0);
    end else begin
      for (int i = 0; i < 6; i++) begin
        tests++;
        if (wq[w0 + i] !== 16'(200 + 3 * i) || lq[w0 + i] !== (i == 5)) begin
          fails++; $display("FAIL bp_word%0d: data=%0d last=%b required %0d %b", i, wq[w0 + i], lq[w0 + i], 200 + 3 * i, i == 5);
        end
      end
    end
    tests++;
    if (stall_err !== 0) begin fails++; $display("FAIL bp_stable: unstable stalls=%0d required 0", stall_err); end
    tests++;
    if (max_oc > 2) begin fails++; $display("FAIL bp_occupancy: max=%0d required <=2", max_oc); end
  endtask

  task automatic test_len0_and_ignored_start();
    int r0, v0, w0;
    bit ok;
    @(posedge clk); #2 start = 1'b1; len = 5'd0; r0 = rd_total; v0 = val_total;
    @(posedge clk); #2 start = 1'b0;
    @(negedge clk);
    tests++;
    if ({done, busy, out_valid} !== 3'b100) begin
      fails++; $display("FAIL len0_done: done/busy/valid=%b required 100", {done, busy, out_valid});
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL len0_pulse: done=%b required 0", done); end
    @(posedge clk); #2;
    tests++;
    if (rd_total !== r0 || val_total !== v0) begin
      fails++; $display("FAIL len0_quiet: reads=%0d valids=%0d required 0 0", rd_total - r0, val_total - v0);
    end
    for (int i = 0; i < 8; i++) mem[i] = 16'(100 + i);
    start = 1'b1; len = 5'd4; r0 = rd_total; w0 = wq.size();
    @(posedge clk); #2 start = 1'b0;
    @(posedge clk); #2 start = 1'b1; len = 5'd7;
    @(posedge clk); #2 start = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 30 && !ok; k++) begin @(negedge clk); ok = done; end
    tests++;
    if (!ok) begin fails++; $display("FAIL ign_done_timeout: done=0 required 1"); end
    @(posedge clk); #2;
    tests++;
    if (wq.size() - w0 !== 4 || rd_total - r0 !== 4) begin
      fails++; $display("FAIL ign_count: words=%0d reads=%0d required 4 4", wq.size() - w0, rd_total - r0);
    end else if (wq[w0 + 3] !== 16'd103 || lq[w0 + 3] !== 1'b1) begin
      fails++; $display("FAIL ign_last: data=%0d last=%b required 103 1", wq[w0 + 3], lq[w0 + 3]);
    end
  endtask

  task automatic test_clear();
    int h, w0;
    bit ok, bad;
    for (int i = 0; i < 8; i++) mem[i] = 16'(300 + i);
    @(posedge clk); #2 start = 1'b1; len = 5'd8; out_ready = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    h = 0;
    for (int k = 0; k < 20 && h < 3; k++) begin @(negedge clk); if (out_valid && out_ready) h++; end
    tests++;
    if (h !== 3) begin fails++; $display("FAIL clr_wait: handshakes=%0d required 3", h); end
    @(posedge clk); #2 clear = 1'b1;
    @(posedge clk); #2 clear = 1'b0;
    @(negedge clk);
    tests++;
    if ({out_valid, busy, done} !== 3'b000) begin
      fails++; $display("FAIL clr_state: valid/busy/done=%b required 000", {out_valid, busy, done});
    end
    bad = 1'b0;
    for (int k = 0; k < 4; k++) begin @(negedge clk); if (done || out_valid) bad = 1'b1; end
    tests++;
    if (bad) begin fails++; $display("FAIL clr_quiet: done or valid seen=1 required 0"); end
    @(posedge clk); #2 start = 1'b1; len = 5'd2; w0 = wq.size();
    @(posedge clk); #2 start = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin @(negedge clk); ok = done; end
    tests++;
    if (!ok) begin fails++; $display("FAIL clr_restart_timeout: done=0 required 1"); end
    @(posedge clk); #2;
    tests++;
    if (wq.size() - w0 !== 2) begin
      fails++; $display("FAIL clr_restart_count: words=%0d required 2", wq.size() - w0);
    end else if (wq[w0] !== 16'd300 || wq[w0 + 1] !== 16'd301 || {lq[w0], lq[w0 + 1]} !== 2'b01) begin
      fails++; $display("FAIL clr_restart_words: %0d %0d last=%b%b required 300 301 01",
        wq[w0], wq[w0 + 1], lq[w0], lq[w0 + 1]);
    end
  endtask

  task automatic test_relu();
    int w0;
    bit ok;
    logic [DW-1:0] exp_w [4];
`ifdef PSUM_DRAIN_RELU_EN
    exp_w = '{16'h0000, 16'h0007, 16'h0000, 16'h0003};
`else
    exp_w = '{16'hFFFB, 16'h0007, 16'h8000, 16'h0003};
`endif
    mem[0] = 16'hFFFB; mem[1] = 16'h0007; mem[2] = 16'h8000; mem[3] = 16'h0003;
    @(posedge clk); #2 start = 1'b1; len = 5'd4; w0 = wq.size();
    @(posedge clk); #2 start = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin @(negedge clk); ok = done; end
    tests++;
    if (!ok) begin fails++; $display("FAIL relu_done_timeout: done=0 required 1"); end
    @(posedge clk); #2;
    tests++;
    if (wq.size() - w0 !== 4) begin
      fails++; $display("FAIL relu_count: words=%0d required 4", wq.size() - w0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (wq[w0 + i] !== exp_w[i]) begin
          fails++; $display("FAIL relu_word%0d: got %h required %h", i, wq[w0 + i], exp_w[i]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    bit bad;
    for (int i = 0; i < 8; i++) mem[i] = 16'(300 + i);
    @(posedge clk); #2 start = 1'b1; len = 5'd8;
    @(posedge clk); #2 start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rstn = 1'b0;
    #1;
    tests++;
    if ({busy, done, rd_en, out_valid, out_last} !== 5'b0 || rd_addr !== '0 || out_data !== '0) begin
      fails++; $display("FAIL async_reset: flags=%b rd_addr=%0d out_data=%0d required 00000 0 0",
        {busy, done, rd_en, out_valid, out_last}, rd_addr, out_data);
    end
    @(posedge clk);
    @(posedge clk); #2 rstn = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 4; k++) begin @(negedge clk); if (done || busy || out_valid) bad = 1'b1; end
    tests++;
    if (bad) begin fails++; $display("FAIL async_after: done/busy/valid seen=1 required 0"); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_len0_and_ignored_start();
    test_clear();
    test_relu();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/psum_drain_ctrl.md
Name: psum_drain_ctrl

Overview:
Read-side companion of the PE psum write-address counter. On a start pulse it sweeps the psum scratchpad from address 0 to len-1 and issues one read per entry; SRAM read latency is fixed at 1 cycle. It streams the returned psums out over a valid/ready handshake toward the next PE or the GLB, and marks the final word with out_last. A 2-entry output buffer sustains 1 word/cycle while out_ready stays high.

Parameters:
DATA_W, 16, psum data width (two's complement)
ADDR_W, 5, scratchpad address width; also width of len

Ports:
clk  input  1  clock, all state updates on rising edge
rstn  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a drain of len entries
len  input  ADDR_W  number of entries to drain; sampled only when start is accepted
clear  input  1  synchronous abort; returns block to IDLE and flushes buffer
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse after the last word handshakes (or after clear-free len=0 start)
rd_en  output  1  scratchpad read strobe
rd_addr  output  ADDR_W  scratchpad read address
rd_data  input  DATA_W  scratchpad data, valid the cycle after rd_en
out_valid  output  1  out_data holds a valid psum
out_ready  input  1  downstream accepts when out_valid and out_ready are both high
out_data  output  DATA_W  streamed psum
out_last  output  1  high with the final word of a drain

Behaviour:
- Reset (rstn low, async): state IDLE; busy, done, rd_en, out_valid, out_last = 0; rd_addr = 0; out_data = 0; buffer empty; inflight = 0.
- States: IDLE, ISSUE, FLUSH, DONE.
- IDLE: start=1 with len!=0 -> latch len, issue_cnt=0, go to ISSUE. start=1 with len==0 -> go to DONE, with no reads. start while not IDLE is ignored.
- ISSUE: rd_en=1, rd_addr=issue_cnt only when (occupancy + inflight - pop) < 2. pop = out_valid & out_ready in the same cycle. Each issue increments issue_cnt. After issue_cnt reaches len-1 and that read is issued -> FLUSH.
- inflight: set on a rd_en cycle, cleared the next cycle when rd_data is written into the buffer. At most 1.
- Buffer: 2-entry FIFO. rd_data is pushed on the cycle after rd_en. out_valid = buffer not empty. out_data is the head entry.
- Handshake rules: out_data and out_last stay stable while out_valid=1 and out_ready=0. Push and pop in the same cycle are legal. The buffer never overflows, because of the issue rule.
- out_last = 1 on the head entry that was read from address len-1.
- FLUSH: no reads. When the out_last word handshakes -> DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0 in IDLE and DONE.
- Throughput: with out_ready held high, the first out_valid appears 2 cycles after the start cycle, then 1 word per cycle. A drain of N words takes N+2 cycles from start to the last handshake.
- rd_addr is ADDR_W wide. len up to 2^ADDR_W-1 is supported, with no wrap-around. After the last issue, rd_addr holds its final value.
- clear: has priority over start and all other activity. Next cycle: IDLE, buffer empty, inflight=0, out_valid=0, no done pulse. Any rd_data returning from a read issued in the clear cycle is discarded.
- Reset asserted mid-drain: immediate return to reset values; no done pulse.

Optional Feature:
PSUM_DRAIN_RELU_EN
- Defined: out_data is set to 0 when the head entry is negative (MSB=1); otherwise it is passed unchanged. The clamp is combinational on the buffer output and adds no latency.
- Undefined: out_data is the raw scratchpad value.

Test Plan:
- Basic drain: reset; scratchpad[i]=i+100 for i=0..3; start with len=4, out_ready=1 -> out_data is 100,101,102,103 on consecutive cycles starting at cycle 2; out_last on 103; done pulses 1 cycle later; exactly 4 rd_en pulses.
- Backpressure: len=6, out_ready toggles 1,0,0,1,... -> no word lost or duplicated; out_data is stable while stalled; occupancy never exceeds 2; rd_en is suppressed when the buffer plus in-flight read is full.
- len=0 and start while busy: start with len=0 -> done after 1 cycle, no rd_en, no out_valid. Start pulse during an active len=4 drain -> ignored; exactly 4 words delivered.
- Clear mid-drain: len=8, clear after the 3rd handshake -> next cycle out_valid=0, busy=0, no done. A following start with len=2 delivers addresses 0,1 cleanly.
- Async reset: drop rstn mid-drain between clock edges -> outputs reach reset values before the next edge.
- RELU (macro defined): scratchpad = {-5, 7, 0x8000, 3} -> out_data = 0, 7, 0, 3. With the macro undefined -> 0xFFFB, 7, 0x8000, 3.
